rv32m_muldiv: RTL and testbench
===============================

Name: rv32m_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the two register-file read operands and produces one 32-bit result plus destination index for the register-file write port.
- Fixed-latency, multi-cycle. Holds off the pipeline via busy_o and emits a single-cycle done_o write-back strobe.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- ADDR_BUS_WIDTH, 5, destination register index width.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  request; accepted only when busy_o=0.
- funct3_i  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  input  DATA_WIDTH  operand A (dividend/multiplicand).
- rs2_data_i  input  DATA_WIDTH  operand B (divisor/multiplier).
- rd_addr_i  input  ADDR_BUS_WIDTH  destination index.
- kill_i  input  1  pipeline flush; aborts the current op.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle result-valid / write-enable strobe.
- result_o  output  DATA_WIDTH  result; valid only while done_o=1.
- rd_addr_o  output  ADDR_BUS_WIDTH  captured rd, paired with done_o.

Behaviour:
- Reset (async, reset_i=0):
  - State=IDLE.
  - busy_o=0, done_o=0, result_o=0, rd_addr_o=0.
  - Counter and accumulators cleared.
  - Reset mid-operation discards the op; no done_o follows.
- FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - On start_i=1 (and kill_i=0), capture funct3, rd and operands; go to CALC with cnt=0.
  - Signed ops take magnitudes of the signed operands:
    - MULH: both operands signed.
    - MULHSU: rs1 signed only.
    - DIV/REM: both operands signed.
  - Record result sign:
    - MUL*: XOR of the operand signs.
    - DIV: XOR of the operand signs.
    - REM: sign of the dividend.
- CALC: one iteration per clock, cnt 0..31; at cnt==31 go to FIX (32 cycles).
  - Multiply: unsigned shift-add into a 64-bit product.
  - Divide: restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
- FIX:
  - Negate (two's complement) the 64-bit product or the quotient/remainder if the recorded sign is set.
  - Select the result:
    - MUL: product[31:0].
    - MULH/MULHSU/MULHU: product[63:32].
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register result_o; go to DONE.
- DONE: done_o=1 and busy_o=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge E0 -> done_o high during the cycle following edge E0+33; next start is accepted one cycle after done_o.
- result_o and rd_addr_o hold their values after done_o falls until the next FIX.
- start_i while busy_o=1: ignored (no queueing), including in the DONE cycle.
- kill_i=1 in any state: next state IDLE, done_o=0 next cycle. kill_i has priority over start_i in the same cycle.
- Divide by zero (checked at capture, still takes full latency):
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU remainder = rs1.
- Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF):
  - DIV = 0x80000000.
  - REM = 0.
- Operand inputs need not stay stable after the accepting edge.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU computed with a single-cycle 33x33 signed multiplier at the accepting edge.
  - FSM goes IDLE -> DONE, so done_o is high in the cycle after E0 (latency 1).
  - Divide ops are unchanged.
- Undefined: all ops use the iterative 34-cycle path. No multiplier operator is inferred.

Test Plan:
- MUL 7 x -3 (rs1=0x00000007, rs2=0xFFFFFFFD) -> done_o after 33 cycles, result_o=0xFFFFFFEB, rd_addr_o=captured rd.
- MULH 0x80000000 x 0x80000000 -> result_o=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5. Overflow: DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- start_i held high through an op: exactly one done_o, second request accepted only after IDLE. kill_i at cycle 10 -> busy_o=0 next cycle, no done_o.
- reset_i pulsed low mid-CALC -> all outputs 0 immediately, no done_o. With MULDIV_FAST_MUL_EN defined, MUL 6x7 -> done_o one cycle after start, result_o=42.

Source files
------------

// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv -- iterative RV32M multiply/divide unit for the execute stage.
//
// Takes the two register-file read operands, runs a fixed-latency iterative
// multiply (shift-add) or divide (restoring shift-subtract), and emits one
// 32-bit result plus the captured destination index with a one-cycle done_o
// write-back strobe. busy_o holds off the pipeline in every non-IDLE state.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   defined   : MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed
//               multiplier at the accepting edge (IDLE -> DONE, latency 1).
//   undefined : every op uses the iterative IDLE->CALC->FIX->DONE path and
//               no multiplier operator is inferred.
//
// Ports:
//   clk_i       clock
//   reset_i     asynchronous active-low reset
//   start_i     request, accepted only while busy_o=0
//   funct3_i    RV32M op select (MUL..REMU)
//   rs1_data_i  operand A (multiplicand / dividend)
//   rs2_data_i  operand B (multiplier / divisor)
//   rd_addr_i   destination register index
//   kill_i      pipeline flush, aborts the current op (priority over start_i)
//   busy_o      high in every state except IDLE
//   done_o      one-cycle result-valid / write-enable strobe
//   result_o    result, valid while done_o=1, held until the next result
//   rd_addr_o   destination index paired with done_o
module rv32m_muldiv #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_BUS_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [2:0]                funct3_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [ADDR_BUS_WIDTH-1:0] rd_addr_i,
    input  logic                      kill_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DATA_WIDTH-1:0]     result_o,
    output logic [ADDR_BUS_WIDTH-1:0] rd_addr_o
);

    localparam int DW = DATA_WIDTH;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
        return neg ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t                r_state;
    logic [4:0]            r_cnt;
    logic [2:0]            r_funct3;
    logic [ADDR_BUS_WIDTH-1:0] r_rd;
    logic                  r_sign;
    logic [DW-1:0]         r_hi;   // product high half / partial remainder
    logic [DW-1:0]         r_lo;   // multiplier shifting out / dividend->quotient
    logic [DW-1:0]         r_op;   // multiplicand / divisor magnitude
    logic                  r_busy;
    logic                  r_done;
    logic [DW-1:0]         r_result;
    logic [ADDR_BUS_WIDTH-1:0] r_rd_out;

    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DW-1:0]         w_a_mag;
    logic [DW-1:0]         w_b_mag;
    logic                  w_sign;
    logic [DW:0]           w_mul_sum;
    logic [DW+1:0]         w_div_sub;
    logic [DW-1:0]         w_next_hi;
    logic [DW-1:0]         w_next_lo;
    logic [2*DW-1:0]       w_prod_fix;
    logic [DW-1:0]         w_fix_result;
`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*DW-1:0] w_fast_prod;
    logic [DW-1:0]          w_fast_result;
`endif

    // Operand sign/magnitude decode and recorded result sign at capture.
    always_comb begin
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
        w_sign  = 1'b0;
        case (funct3_i)
            F_MULH, F_DIV, F_REM: begin
                w_a_neg = rs1_data_i[DW-1];
                w_b_neg = rs2_data_i[DW-1];
            end
            F_MULHSU: begin
                w_a_neg = rs1_data_i[DW-1];
                w_b_neg = 1'b0;
            end
            default: begin
                w_a_neg = 1'b0;
                w_b_neg = 1'b0;
            end
        endcase
        w_a_mag = cond_neg(rs1_data_i, w_a_neg);
        w_b_mag = cond_neg(rs2_data_i, w_b_neg);
        if (!funct3_i[2]) begin
            w_sign = w_a_neg ^ w_b_neg;
        end else if (funct3_i[1]) begin
            w_sign = w_a_neg;                        // remainder follows dividend
        end else if (rs2_data_i == {DW{1'b0}}) begin
            w_sign = 1'b0;                           // x/0 quotient stays all-ones
        end else begin
            w_sign = w_a_neg ^ w_b_neg;
        end
    end

    // One shift-add or restoring shift-subtract iteration.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : {(DW+1){1'b0}});
        w_div_sub = {1'b0, r_hi, r_lo[DW-1]} - {2'b00, r_op};
        w_next_hi = r_hi;
        w_next_lo = r_lo;
        if (r_funct3[2]) begin
            if (w_div_sub[DW+1]) begin
                w_next_hi = {r_hi[DW-2:0], r_lo[DW-1]};
                w_next_lo = {r_lo[DW-2:0], 1'b0};
            end else begin
                w_next_hi = w_div_sub[DW-1:0];
                w_next_lo = {r_lo[DW-2:0], 1'b1};
            end
        end else begin
            w_next_hi = w_mul_sum[DW:1];
            w_next_lo = {w_mul_sum[0], r_lo[DW-1:1]};
        end
    end

    // Sign fix-up and result selection for the FIX state.
    always_comb begin
        w_prod_fix = r_sign ? (~{r_hi, r_lo} + {{(2*DW-1){1'b0}}, 1'b1}) : {r_hi, r_lo};
        case (r_funct3)
            F_MUL:                     w_fix_result = w_prod_fix[DW-1:0];
            F_MULH, F_MULHSU, F_MULHU: w_fix_result = w_prod_fix[2*DW-1:DW];
            F_DIV, F_DIVU:             w_fix_result = cond_neg(r_lo, r_sign);
            F_REM, F_REMU:             w_fix_result = cond_neg(r_hi, r_sign);
            default:                   w_fix_result = {DW{1'b0}};
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle 33x33 signed multiply; the low 64 bits of the product are exact.
    always_comb begin
        w_fast_prod = $signed({{(DW-1){w_a_neg}}, (w_a_neg | (funct3_i == F_MULH) | (funct3_i == F_MULHSU)) & rs1_data_i[DW-1], rs1_data_i})
                    * $signed({{(DW-1){w_b_neg}}, (funct3_i == F_MULH) & rs2_data_i[DW-1], rs2_data_i});
        if (funct3_i == F_MUL) begin
            w_fast_result = w_fast_prod[DW-1:0];
        end else begin
            w_fast_result = w_fast_prod[2*DW-1:DW];
        end
    end
`endif

    // Control FSM with registered busy/done/result/rd outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_funct3 <= 3'b000;
            r_rd     <= {ADDR_BUS_WIDTH{1'b0}};
            r_sign   <= 1'b0;
            r_hi     <= {DW{1'b0}};
            r_lo     <= {DW{1'b0}};
            r_op     <= {DW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {DW{1'b0}};
            r_rd_out <= {ADDR_BUS_WIDTH{1'b0}};
        end else if (kill_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_funct3 <= funct3_i;
                        r_rd     <= rd_addr_i;
                        r_sign   <= w_sign;
                        r_cnt    <= 5'd0;
                        r_hi     <= {DW{1'b0}};
                        // Multiply shifts the multiplier out of r_lo; divide shifts the dividend.
                        r_lo     <= funct3_i[2] ? w_a_mag : w_b_mag;
                        r_op     <= funct3_i[2] ? w_b_mag : w_a_mag;
                        r_busy   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        if (!funct3_i[2]) begin
                            r_result <= w_fast_result;
                            r_rd_out <= rd_addr_i;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
`else
                        r_state  <= S_CALC;
`endif
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_hi  <= w_next_hi;
                    r_lo  <= w_next_lo;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_rd_out <= r_rd;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign result_o  = r_result;
    assign rd_addr_o = r_rd_out;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Self-checking bench for rv32m_muldiv: directed vectors, expected results
// queued at issue time and compared by an independent done_o monitor.
module tb_rv32m_muldiv;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        kill_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    always #5 clk_i = ~clk_i;

    rv32m_muldiv #(.DATA_WIDTH(32), .ADDR_BUS_WIDTH(5)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .kill_i     (kill_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_addr_o  (rd_addr_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done_o strobe must match the oldest queued result.
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 result 0x%08h expected no pending op", result_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result_o, mon_e[31:0]);
                check("rd_addr", {27'd0, rd_addr_o}, {27'd0, mon_e[36:32]});
            end
        end
    end

    // Wait (bounded) for done_o; returns negedges counted after the accepting edge, 0 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int n;
        @(negedge clk_i);
        exp_q.push_back({rd, exp});
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = rd;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i    = 1'b0;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        rd_addr_i  = 5'($urandom);
        wait_done(n);
        check({name, "_latency"}, 32'(n), 32'(f3[2] ? DIV_LAT : MUL_LAT));
        @(negedge clk_i);
        check({name, "_hold"}, result_o, exp);
        check({name, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int n;
        reset_i    = 1'b0;
        start_i    = 1'b0;
        kill_i     = 1'b0;
        funct3_i   = 3'b000;
        rs1_data_i = 32'd0;
        rs2_data_i = 32'd0;
        rd_addr_i  = 5'd0;
        repeat (2) @(negedge clk_i);
        check("rst_busy",   {31'd0, busy_o}, 32'd0);
        check("rst_done",   {31'd0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_rd",     {27'd0, rd_addr_o}, 32'd0);
        reset_i = 1'b1;

        run_op("mul",     3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
        run_op("mul67",   3'b000, 32'd6,        32'd7,        5'd6,  32'd42);
        run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000);
        run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE);
        run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFF);
        run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD);
        run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF);
        run_op("divu",    3'b101, 32'd100,      32'd7,        5'd12, 32'd14);
        run_op("remu",    3'b111, 32'd100,      32'd7,        5'd13, 32'd2);
        run_op("div0",    3'b100, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF);
        run_op("rem0",    3'b110, 32'd5,        32'd0,        5'd15, 32'd5);
        run_op("divneg0", 3'b100, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFF);
        run_op("remneg0", 3'b110, 32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFB);
        run_op("divovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000);
        run_op("removf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0);

        // start_i held high: DONE cycle ignores it, the next IDLE cycle accepts it.
        @(negedge clk_i);
        exp_q.push_back({5'd20, 32'd14});
        exp_q.push_back({5'd20, 32'd14});
        funct3_i   = 3'b101;
        rs1_data_i = 32'd100;
        rs2_data_i = 32'd7;
        rd_addr_i  = 5'd20;
        start_i    = 1'b1;
        wait_done(n);
        check("held_latency", 32'(n), 32'(DIV_LAT));
        check("held_busy_in_done", {31'd0, busy_o}, 32'd1);
        @(negedge clk_i);
        check("held_idle_gap", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(n);
        check("held_second_latency", 32'(n), 32'(DIV_LAT));
        @(negedge clk_i);

        // kill after 10 cycles: busy drops next cycle and no done_o ever appears.
        @(negedge clk_i);
        funct3_i   = 3'b101;
        rs1_data_i = 32'd1000;
        rs2_data_i = 32'd3;
        rd_addr_i  = 5'd21;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("kill_busy_before", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        check("kill_busy", {31'd0, busy_o}, 32'd0);
        check("kill_done", {31'd0, done_o}, 32'd0);
        repeat (40) @(negedge clk_i);

        // kill has priority over start in the same cycle.
        start_i = 1'b1;
        kill_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        kill_i  = 1'b0;
        check("kill_prio_busy", {31'd0, busy_o}, 32'd0);

        // Reset mid-CALC clears outputs immediately and discards the op.
        @(negedge clk_i);
        funct3_i   = 3'b101;
        rs1_data_i = 32'd100;
        rs2_data_i = 32'd7;
        rd_addr_i  = 5'd22;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        check("mid_rst_busy",   {31'd0, busy_o}, 32'd0);
        check("mid_rst_done",   {31'd0, done_o}, 32'd0);
        check("mid_rst_result", result_o, 32'd0);
        check("mid_rst_rd",     {27'd0, rd_addr_o}, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (40) @(negedge clk_i);

        // Normal operation resumes after reset.
        run_op("post_rst_mul", 3'b000, 32'd6, 32'd7, 5'd23, 32'd42);

        repeat (3) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
